// File: rtl/stopwatch_pkg.sv
// Shared types and defaults for the stopwatch controller.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package stopwatch_pkg;

    localparam int unsigned NUM_DIGITS        = 6;
    localparam int unsigned CLR_CYCLES_DEF    = 2;
    localparam int unsigned SETTLE_CYCLES_DEF = 1;

    typedef enum logic [2:0] {
        ST_CLR    = 3'd0,
        ST_SETTLE = 3'd1,
        ST_IDLE   = 3'd2,
        ST_RUN    = 3'd3,
        ST_PAUSE  = 3'd4,
        ST_LAP    = 3'd5,
        ST_OVF    = 3'd6
    } ctrl_state_t;

    // Phase of the clear sequencer; OFF once the chain is out of reset and settled.
    typedef enum logic [1:0] {
        PH_OFF    = 2'd0,
        PH_CLR    = 2'd1,
        PH_SETTLE = 2'd2
    } seq_phase_t;

endpackage

// File: rtl/stopwatch_ctrl_if.sv
// Bundle of pulse/strobe inputs and control outputs of the stopwatch controller.
// Latency: n/a (wiring only).
// Backpressure: none; all signals are single-cycle strobes or levels.
interface stopwatch_ctrl_if;
    logic       tick_in;
    logic       start_stop_pls;
    logic       clear_pls;
    logic       lap_pls;
    logic       chain_all_max;
    logic       cnt_ena;
    logic       cnt_rst;
    logic       disp_latch;
    logic       running;
    logic       overflow;
    logic [2:0] state_o;

    // Button conditioners, prescaler and counter chain side.
    modport master (
        output tick_in, start_stop_pls, clear_pls, lap_pls, chain_all_max,
        input  cnt_ena, cnt_rst, disp_latch, running, overflow, state_o
    );

    // Controller side.
    modport slave (
        input  tick_in, start_stop_pls, clear_pls, lap_pls, chain_all_max,
        output cnt_ena, cnt_rst, disp_latch, running, overflow, state_o
    );
endinterface

// File: rtl/stopwatch_ctrl_clr_sequencer.sv
// Clear sequencer: holds cnt_rst for CLR_CYCLES, then idles SETTLE_CYCLES.
// Latency: cnt_rst registered; clr_done_o/done_o flag the last CLR/SETTLE cycle.
// Backpressure: none; load_i restarts the sequence at any time.
module clr_sequencer
    import stopwatch_pkg::*;
#(
    parameter int unsigned CLR_CYCLES    = CLR_CYCLES_DEF,
    parameter int unsigned SETTLE_CYCLES = SETTLE_CYCLES_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load_i,
    output logic cnt_rst_o,
    output logic clr_done_o,
    output logic done_o
);
    localparam int unsigned MAXC = (CLR_CYCLES > SETTLE_CYCLES) ? CLR_CYCLES : SETTLE_CYCLES;
    localparam int unsigned CW   = (MAXC > 1) ? $clog2(MAXC) : 1;
    localparam logic [CW-1:0] CLR_LOAD = CW'(CLR_CYCLES - 1);
    localparam logic [CW-1:0] SET_LOAD = (SETTLE_CYCLES > 0) ? CW'(SETTLE_CYCLES - 1) : '0;

    seq_phase_t    phase_q, phase_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          cnt_rst_q;

    assign cnt_rst_o  = cnt_rst_q;
    assign clr_done_o = (phase_q == PH_CLR) && (cnt_q == '0);
    // With no settle time the clear itself completes the sequence.
    assign done_o     = ((phase_q == PH_SETTLE) && (cnt_q == '0)) ||
                        (clr_done_o && (SETTLE_CYCLES == 0));

    // Down-counter walking CLR -> SETTLE -> OFF; load_i restarts from CLR.
    always_comb begin
        phase_d = phase_q;
        cnt_d   = cnt_q;
        if (load_i) begin
            phase_d = PH_CLR;
            cnt_d   = CLR_LOAD;
        end else begin
            case (phase_q)
                PH_CLR: begin
                    if (cnt_q == '0) begin
                        phase_d = (SETTLE_CYCLES == 0) ? PH_OFF : PH_SETTLE;
                        cnt_d   = SET_LOAD;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
                PH_SETTLE: begin
                    if (cnt_q == '0) begin
                        phase_d = PH_OFF;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Phase/count registers; reset lands in CLR with the counter reloaded.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_q   <= PH_CLR;
            cnt_q     <= CLR_LOAD;
            cnt_rst_q <= 1'b1;
        end else begin
            phase_q   <= phase_d;
            cnt_q     <= cnt_d;
            cnt_rst_q <= (phase_d == PH_CLR);
        end
    end
endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch control FSM: run/pause, clear, lap freeze and overflow halt.
// Latency: all outputs registered; a tick in cycle N gives cnt_ena in N+1.
// Backpressure: none; pulses outside their accepting states are dropped.
module stopwatch_ctrl
    import stopwatch_pkg::*;
#(
    parameter int unsigned CLR_CYCLES    = CLR_CYCLES_DEF,
    parameter int unsigned SETTLE_CYCLES = SETTLE_CYCLES_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    stopwatch_ctrl_if.slave  sw
);
    ctrl_state_t state_q, state_d;
    logic        cnt_ena_q, cnt_ena_d;
    logic        disp_latch_q, disp_latch_d;
    logic        running_q, running_d;
    logic        overflow_q, overflow_d;
    logic        seq_load, seq_clr_done, seq_done;
    logic        tick_ovf, counting;

    assign tick_ovf = sw.tick_in && sw.chain_all_max;
    assign counting = (state_q == ST_RUN) || (state_q == ST_LAP);
    // Any fresh entry into CLR (including recovery from an illegal code) restarts the clear.
    assign seq_load = (state_d == ST_CLR) && (state_q != ST_CLR);

    clr_sequencer #(
        .CLR_CYCLES    (CLR_CYCLES),
        .SETTLE_CYCLES (SETTLE_CYCLES)
    ) u_clr_seq (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (seq_load),
        .cnt_rst_o  (sw.cnt_rst),
        .clr_done_o (seq_clr_done),
        .done_o     (seq_done)
    );

    // Next state and next registered outputs; priority clear > start/stop > overflow > lap.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_CLR: begin
                if (seq_done)          state_d = ST_IDLE;
                else if (seq_clr_done) state_d = ST_SETTLE;
            end
            ST_SETTLE: begin
                if (seq_done) state_d = ST_IDLE;
            end
            ST_IDLE: begin
                if (sw.clear_pls)           state_d = ST_CLR;
                else if (sw.start_stop_pls) state_d = ST_RUN;
            end
            ST_RUN: begin
                if (sw.clear_pls)           state_d = ST_CLR;
                else if (sw.start_stop_pls) state_d = ST_PAUSE;
                else if (tick_ovf)          state_d = ST_OVF;
                else if (sw.lap_pls)        state_d = ST_LAP;
            end
            ST_LAP: begin
                if (sw.clear_pls)           state_d = ST_CLR;
                else if (sw.start_stop_pls) state_d = ST_PAUSE;
                else if (tick_ovf)          state_d = ST_OVF;
                else if (sw.lap_pls)        state_d = ST_RUN;
            end
            ST_PAUSE: begin
                if (sw.clear_pls)           state_d = ST_CLR;
                else if (sw.start_stop_pls) state_d = ST_RUN;
            end
            ST_OVF: begin
                if (sw.clear_pls) state_d = ST_CLR;
            end
            default: state_d = ST_CLR;
        endcase

        // Count only ticks seen while counting and still counting next cycle.
        cnt_ena_d = sw.tick_in && counting &&
                    ((state_d == ST_RUN) || (state_d == ST_LAP));

        // Display frozen in LAP, and in a PAUSE entered from LAP until lap releases it.
        disp_latch_d = 1'b1;
        if (state_d == ST_LAP) begin
            disp_latch_d = 1'b0;
        end else if (state_d == ST_PAUSE) begin
            if (state_q == ST_PAUSE)    disp_latch_d = sw.lap_pls ? 1'b1 : disp_latch_q;
            else if (state_q == ST_LAP) disp_latch_d = 1'b0;
        end

        running_d  = (state_d == ST_RUN) || (state_d == ST_LAP);
        overflow_d = (state_d == ST_OVF);
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_CLR;
            cnt_ena_q    <= 1'b0;
            disp_latch_q <= 1'b1;
            running_q    <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_ena_q    <= cnt_ena_d;
            disp_latch_q <= disp_latch_d;
            running_q    <= running_d;
            overflow_q   <= overflow_d;
        end
    end

    assign sw.cnt_ena    = cnt_ena_q;
    assign sw.disp_latch = disp_latch_q;
    assign sw.running    = running_q;
    assign sw.overflow   = overflow_q;
    assign sw.state_o    = state_q;
endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Bench for stopwatch_ctrl: table of per-cycle inputs and expected outputs.
// Expected output records go through a scoreboard queue, compared #1 after each edge.
// Ends with a hand-written asynchronous reset in the middle of a run.
module tb_stopwatch_ctrl;
    logic clk;
    logic rst_n;

    stopwatch_ctrl_if sw ();

    stopwatch_ctrl u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .sw    (sw)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic       rst_n;
        logic       tick;
        logic       ss;
        logic       clr;
        logic       lap;
        logic       mx;
        logic [7:0] exp;   // {state[2:0], cnt_ena, cnt_rst, disp_latch, running, overflow}
    } vec_t;

    vec_t       vecs[$];
    logic [7:0] sb_q[$];
    int         n_checks = 0;
    int         n_errors = 0;

    function automatic void add(int rn, int tk, int ss, int cl, int lp, int mx,
                                int st, int en, int rs, int la, int ru, int ov);
        vec_t v;
        v.rst_n = (rn != 0);
        v.tick  = (tk != 0);
        v.ss    = (ss != 0);
        v.clr   = (cl != 0);
        v.lap   = (lp != 0);
        v.mx    = (mx != 0);
        v.exp   = {3'(st), (en != 0), (rs != 0), (la != 0), (ru != 0), (ov != 0)};
        vecs.push_back(v);
    endfunction

    function automatic logic [7:0] actual();
        return {sw.state_o, sw.cnt_ena, sw.cnt_rst, sw.disp_latch, sw.running, sw.overflow};
    endfunction

    task automatic check(input string name, input logic [7:0] exp);
        logic [7:0] act;
        act = actual();
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got state=%0d ena/rst/latch/run/ovf=%b, required state=%0d ena/rst/latch/run/ovf=%b",
                     name, act[7:5], act[4:0], exp[7:5], exp[4:0]);
        end
    endtask

    initial begin
        rst_n             = 1'b0;
        sw.tick_in        = 1'b0;
        sw.start_stop_pls = 1'b0;
        sw.clear_pls      = 1'b0;
        sw.lap_pls        = 1'b0;
        sw.chain_all_max  = 1'b0;

        //  rn tk ss cl lp mx   st en rs la ru ov
        // reset held, then release: 2 cycles of cnt_rst, 1 settle, idle
        add(0, 0, 0, 0, 0, 0,   0, 0, 1, 1, 0, 0);
        add(0, 0, 0, 0, 0, 0,   0, 0, 1, 1, 0, 0);
        add(0, 0, 0, 0, 0, 0,   0, 0, 1, 1, 0, 0);
        add(1, 0, 0, 0, 0, 0,   0, 0, 1, 1, 0, 0);
        add(1, 1, 1, 1, 1, 0,   1, 0, 0, 1, 0, 0);  // pulses in CLR ignored
        add(1, 1, 1, 1, 0, 0,   2, 0, 0, 1, 0, 0);  // pulses in SETTLE ignored
        add(1, 1, 0, 0, 1, 0,   2, 0, 0, 1, 0, 0);  // lap/tick in IDLE ignored
        add(1, 0, 1, 0, 0, 0,   3, 0, 0, 1, 1, 0);  // start
        for (int i = 0; i < 5; i++) begin
            add(1, 1, 0, 0, 0, 0,   3, 1, 0, 1, 1, 0);
            for (int j = 0; j < 3; j++) add(1, 0, 0, 0, 0, 0,   3, 0, 0, 1, 1, 0);
        end
        add(1, 0, 1, 0, 0, 0,   4, 0, 0, 1, 0, 0);  // pause
        for (int i = 0; i < 3; i++) begin
            add(1, 1, 0, 0, 0, 0,   4, 0, 0, 1, 0, 0);
            for (int j = 0; j < 3; j++) add(1, 0, 0, 0, 0, 0,   4, 0, 0, 1, 0, 0);
        end
        add(1, 1, 1, 0, 0, 0,   3, 0, 0, 1, 1, 0);  // resume; same-cycle tick not counted
        add(1, 1, 0, 0, 0, 0,   3, 1, 0, 1, 1, 0);
        add(1, 0, 0, 0, 1, 0,   5, 0, 0, 0, 1, 0);  // lap freeze
        add(1, 1, 0, 0, 0, 0,   5, 1, 0, 0, 1, 0);  // still counting in LAP
        add(1, 1, 0, 0, 1, 0,   3, 1, 0, 1, 1, 0);  // second lap releases
        add(1, 0, 0, 0, 1, 0,   5, 0, 0, 0, 1, 0);
        add(1, 0, 1, 0, 0, 0,   4, 0, 0, 0, 0, 0);  // pause from LAP keeps freeze
        add(1, 1, 0, 0, 0, 0,   4, 0, 0, 0, 0, 0);
        add(1, 0, 0, 0, 1, 0,   4, 0, 0, 1, 0, 0);  // lap in PAUSE releases freeze
        add(1, 0, 1, 0, 0, 0,   3, 0, 0, 1, 1, 0);
        add(1, 0, 0, 0, 1, 0,   5, 0, 0, 0, 1, 0);
        add(1, 0, 1, 0, 0, 0,   4, 0, 0, 0, 0, 0);
        add(1, 0, 1, 0, 0, 0,   3, 0, 0, 1, 1, 0);  // resume restores latch
        add(1, 1, 1, 0, 0, 0,   4, 0, 0, 1, 0, 0);  // pause beats tick
        add(1, 0, 1, 0, 0, 0,   3, 0, 0, 1, 1, 0);
        add(1, 0, 0, 0, 0, 1,   3, 0, 0, 1, 1, 0);  // all_max without tick
        add(1, 1, 0, 0, 0, 1,   6, 0, 0, 1, 0, 1);  // overflow, no wrap
        add(1, 0, 1, 0, 0, 0,   6, 0, 0, 1, 0, 1);
        add(1, 0, 0, 0, 1, 0,   6, 0, 0, 1, 0, 1);
        add(1, 1, 0, 0, 0, 1,   6, 0, 0, 1, 0, 1);
        add(1, 0, 0, 1, 0, 0,   0, 0, 1, 1, 0, 0);  // clear out of OVF
        add(1, 0, 0, 0, 0, 0,   0, 0, 1, 1, 0, 0);
        add(1, 0, 0, 0, 0, 0,   1, 0, 0, 1, 0, 0);
        add(1, 0, 0, 0, 0, 0,   2, 0, 0, 1, 0, 0);
        add(1, 0, 0, 1, 0, 0,   0, 0, 1, 1, 0, 0);  // clear from IDLE
        add(1, 0, 0, 0, 0, 0,   0, 0, 1, 1, 0, 0);
        add(1, 0, 0, 0, 0, 0,   1, 0, 0, 1, 0, 0);
        add(1, 0, 0, 0, 0, 0,   2, 0, 0, 1, 0, 0);
        add(1, 0, 1, 0, 0, 0,   3, 0, 0, 1, 1, 0);
        add(1, 1, 0, 0, 0, 0,   3, 1, 0, 1, 1, 0);
        add(1, 1, 1, 1, 0, 0,   0, 0, 1, 1, 0, 0);  // clear+start+tick: clear wins
        add(1, 0, 0, 0, 0, 0,   0, 0, 1, 1, 0, 0);
        add(1, 0, 0, 0, 0, 0,   1, 0, 0, 1, 0, 0);
        add(1, 0, 0, 0, 0, 0,   2, 0, 0, 1, 0, 0);
        add(1, 0, 1, 0, 0, 0,   3, 0, 0, 1, 1, 0);
        add(1, 0, 0, 0, 1, 0,   5, 0, 0, 0, 1, 0);
        add(1, 1, 0, 0, 0, 1,   6, 0, 0, 1, 0, 1);  // overflow from LAP sets latch
        add(1, 0, 0, 1, 0, 0,   0, 0, 1, 1, 0, 0);
        add(1, 0, 0, 0, 0, 0,   0, 0, 1, 1, 0, 0);
        add(1, 0, 0, 0, 0, 0,   1, 0, 0, 1, 0, 0);
        add(1, 0, 0, 0, 0, 0,   2, 0, 0, 1, 0, 0);
        add(1, 0, 1, 0, 0, 0,   3, 0, 0, 1, 1, 0);
        add(1, 0, 1, 0, 1, 0,   4, 0, 0, 1, 0, 0);  // start beats lap
        add(1, 0, 1, 0, 1, 0,   3, 0, 0, 1, 1, 0);
        add(1, 0, 0, 0, 1, 0,   5, 0, 0, 0, 1, 0);
        add(1, 0, 1, 1, 1, 0,   0, 0, 1, 1, 0, 0);  // clear beats both
        add(1, 0, 0, 0, 0, 0,   0, 0, 1, 1, 0, 0);
        add(1, 0, 0, 0, 0, 0,   1, 0, 0, 1, 0, 0);
        add(1, 0, 0, 0, 0, 0,   2, 0, 0, 1, 0, 0);
        add(1, 0, 1, 0, 0, 0,   3, 0, 0, 1, 1, 0);
        add(1, 1, 0, 0, 0, 0,   3, 1, 0, 1, 1, 0);

        foreach (vecs[k]) begin
            rst_n             = vecs[k].rst_n;
            sw.tick_in        = vecs[k].tick;
            sw.start_stop_pls = vecs[k].ss;
            sw.clear_pls      = vecs[k].clr;
            sw.lap_pls        = vecs[k].lap;
            sw.chain_all_max  = vecs[k].mx;
            sb_q.push_back(vecs[k].exp);
            @(posedge clk);
            #1;
            check($sformatf("vec%0d", k), sb_q.pop_front());
        end

        // Asynchronous reset between edges while counting: outputs must drop at once.
        sw.tick_in        = 1'b1;
        sw.start_stop_pls = 1'b0;
        sw.clear_pls      = 1'b0;
        sw.lap_pls        = 1'b0;
        sw.chain_all_max  = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset_immediate", {3'd0, 5'b01100});
        @(posedge clk);
        #1;
        check("async_reset_held", {3'd0, 5'b01100});
        sw.tick_in = 1'b0;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("async_release_clr", {3'd0, 5'b01100});
        @(posedge clk);
        #1;
        check("async_release_settle", {3'd1, 5'b00100});

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
